// File: rtl/detectfaces_mul_pkg.sv
// Shared multiplier definitions for the detectfaces multiplier-sharing block.
// Holds the operand/product widths, their typedefs and the full-precision
// unsigned-by-signed multiply, so the RTL and any reference model agree on
// the exact arithmetic.
package detectfaces_mul_pkg;

   localparam int unsigned A_WIDTH = 16;
   localparam int unsigned B_WIDTH = 6;
   localparam int unsigned P_WIDTH = A_WIDTH + B_WIDTH;

   typedef logic        [A_WIDTH-1:0] operand_a_t;
   typedef logic signed [B_WIDTH-1:0] operand_b_t;
   typedef logic signed [P_WIDTH-1:0] product_t;

   // a is zero-extended (always non-negative), b is sign-extended; the full
   // product fits P_WIDTH bits, so no truncation or saturation can occur.
   function automatic product_t mul_signed(input operand_a_t a, input operand_b_t b);
      product_t ea;
      product_t eb;
      ea = product_t'({1'b0, a});
      eb = product_t'(b);
      return ea * eb;
   endfunction

endpackage

// File: rtl/detectfaces_rr_arbiter.sv
// Round-robin arbiter.
// Grants at most one requester per cycle, searching upward from the pointer
// with explicit wrap at NUM_REQ. The pointer moves past the winner only when
// a grant is actually issued.
// Ports:
//   ap_clk, ap_rst : clock, synchronous active-high reset
//   req            : per-requester request
//   enable         : grants allowed this cycle
//   grant          : one-hot grant (zero when disabled or no request)
//   grant_idx      : index of the selected requester (valid when grant != 0)
module detectfaces_rr_arbiter #(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned ID_WIDTH = $clog2(NUM_REQ)
) (
   input  logic                ap_clk,
   input  logic                ap_rst,
   input  logic [NUM_REQ-1:0]  req,
   input  logic                enable,
   output logic [NUM_REQ-1:0]  grant,
   output logic [ID_WIDTH-1:0] grant_idx
);

   logic [ID_WIDTH-1:0] r_ptr;
   logic [ID_WIDTH-1:0] w_idx;
   logic                w_found;
   int unsigned         w_pos;

   always_comb begin
      w_idx   = '0;
      w_found = 1'b0;
      w_pos   = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         w_pos = int'(r_ptr) + k;
         if (w_pos >= NUM_REQ) begin
            w_pos = w_pos - NUM_REQ;
         end
         if (!w_found && req[w_pos]) begin
            w_found = 1'b1;
            w_idx   = w_pos[ID_WIDTH-1:0];
         end
      end
   end

   always_comb begin
      grant = '0;
      if (enable && w_found) begin
         grant = NUM_REQ'(1) << w_idx;
      end
   end

   assign grant_idx = w_idx;

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_ptr <= '0;
      end else if (enable && w_found) begin
         r_ptr <= (w_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
      end
   end

endmodule

// File: rtl/detectfaces_mul_share_arb.sv
// Shared 16-bit unsigned x 6-bit signed multiplier with round-robin access.
// One operand pair is accepted per cycle; its product is registered and
// returned with the requester index one cycle later.
// Ports:
//   ap_clk, ap_rst       : clock, synchronous active-high reset
//   req_valid/req_ready  : per-requester operand handshake (ready one-hot or 0)
//   req_a, req_b         : packed operands, requester i at slice i
//   rsp_valid/rsp_ready  : registered result handshake
//   rsp_id, rsp_data     : issuing requester and signed product
//   busy                 : result pending or any request present
module detectfaces_mul_share_arb #(
   parameter int unsigned NUM_REQ  = 4,
   parameter int unsigned A_WIDTH  = 16,
   parameter int unsigned B_WIDTH  = 6,
   parameter int unsigned P_WIDTH  = 22,
   parameter int unsigned ID_WIDTH = 2
) (
   input  logic                       ap_clk,
   input  logic                       ap_rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
   input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [ID_WIDTH-1:0]        rsp_id,
   output logic [P_WIDTH-1:0]         rsp_data,
   output logic                       busy
);

   import detectfaces_mul_pkg::*;

   logic                r_rsp_valid;
   logic [ID_WIDTH-1:0] r_rsp_id;
   logic [P_WIDTH-1:0]  r_rsp_data;

   logic                w_can_issue;
   logic                w_enable;
   logic [NUM_REQ-1:0]  w_grant;
   logic [ID_WIDTH-1:0] w_idx;
   logic                w_transfer;
   operand_a_t          w_a;
   operand_b_t          w_b;
   product_t            w_prod;

   // A new result may be loaded when the register is empty or draining now.
   assign w_can_issue = !r_rsp_valid || rsp_ready;
   assign w_enable    = w_can_issue && !ap_rst;

   detectfaces_rr_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .ID_WIDTH (ID_WIDTH)
   ) u_arb (
      .ap_clk    (ap_clk),
      .ap_rst    (ap_rst),
      .req       (req_valid),
      .enable    (w_enable),
      .grant     (w_grant),
      .grant_idx (w_idx)
   );

   // Grants are only ever issued to requesting indices, so any grant is a transfer.
   assign w_transfer = |w_grant;
   assign req_ready  = w_grant;

   assign w_a    = req_a[w_idx*A_WIDTH +: A_WIDTH];
   assign w_b    = req_b[w_idx*B_WIDTH +: B_WIDTH];
   assign w_prod = mul_signed(w_a, w_b);

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_rsp_valid <= 1'b0;
         r_rsp_id    <= '0;
         r_rsp_data  <= '0;
      end else if (w_transfer) begin
         r_rsp_valid <= 1'b1;
         r_rsp_id    <= w_idx;
         r_rsp_data  <= w_prod;
      end else if (rsp_ready) begin
         r_rsp_valid <= 1'b0;
      end
   end

   assign rsp_valid = r_rsp_valid;
   assign rsp_id    = r_rsp_id;
   assign rsp_data  = r_rsp_data;
   assign busy      = r_rsp_valid || (|req_valid);

endmodule

// File: tb/tb_detectfaces_mul_share_arb.sv
module tb_detectfaces_mul_share_arb;

   localparam int N = 4;

   logic               ap_clk = 1'b0;
   logic               ap_rst;
   logic [N-1:0]       req_valid;
   logic [N-1:0]       req_ready;
   logic [N*16-1:0]    req_a;
   logic [N*6-1:0]     req_b;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [1:0]         rsp_id;
   logic signed [21:0] rsp_data;
   logic               busy;

   logic [15:0]        ta [N];
   logic signed [5:0]  tb [N];

   int checks = 0;
   int errors = 0;

   always #5 ap_clk = ~ap_clk;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         req_a[i*16 +: 16] = ta[i];
         req_b[i*6 +: 6]   = tb[i];
      end
   end

   detectfaces_mul_share_arb dut (
      .ap_clk    (ap_clk),
      .ap_rst    (ap_rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .busy      (busy)
   );

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: result register contents and round-robin pointer as plain ints.
   bit m_init  = 0;
   int m_valid = 0;
   int m_id    = 0;
   int m_data  = 0;
   int m_ptr   = 0;

   always @(negedge ap_clk) begin
      int g;
      int exp_ready;
      bit can;
      g = -1;
      can = (m_valid == 0) || rsp_ready;
      for (int k = 0; k < N; k++) begin
         if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      exp_ready = (ap_rst || !can || g < 0) ? 0 : (1 << g);
      if (m_init) begin
         chk("model req_ready", int'(req_ready), exp_ready);
         chk("model rsp_valid", int'(rsp_valid), m_valid);
         chk("model rsp_id", int'(rsp_id), m_id);
         chk("model rsp_data", int'(rsp_data), m_data);
         chk("model busy", int'(busy), int'(m_valid != 0 || req_valid != 0));
      end
      // State after the coming rising edge.
      if (ap_rst) begin
         m_init = 1; m_valid = 0; m_id = 0; m_data = 0; m_ptr = 0;
      end else if (exp_ready != 0) begin
         m_valid = 1;
         m_id    = g;
         m_data  = int'(detectfaces_mul_pkg::mul_signed(ta[g], tb[g]));
         m_ptr   = (g + 1) % N;
      end else if (rsp_ready) begin
         m_valid = 0;
      end
   end

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic do_one(input int i, input int a, input int b, input int exp);
      ta[i] = 16'(a);
      tb[i] = 6'(b);
      req_valid = N'(1) << i;
      #1 chk("single ready", int'(req_ready), 1 << i);
      tick();
      req_valid = '0;
      #1;
      chk("single rsp_valid", int'(rsp_valid), 1);
      chk("single rsp_id", int'(rsp_id), i);
      chk("single rsp_data", int'(rsp_data), exp);
   endtask

   initial begin
      int seq [6];
      seq = '{0, 1, 2, 3, 0, 1};
      ap_rst    = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b1;
      for (int i = 0; i < N; i++) begin
         ta[i] = '0;
         tb[i] = '0;
      end
      tick();
      tick();
      ap_rst = 1'b0;
      #1;
      chk("reset rsp_valid", int'(rsp_valid), 0);
      chk("reset rsp_data", int'(rsp_data), 0);
      chk("reset req_ready", int'(req_ready), 0);
      chk("reset busy", int'(busy), 0);

      // Single request and arithmetic extremes.
      do_one(2, 1000, -3, -3000);
      do_one(0, 65535, -32, -2097120);
      do_one(0, 65535, 31, 2031585);
      do_one(0, 0, -1, 0);
      do_one(3, 5, 5, 25);  // leaves pointer at 0

      // Fairness: all requesters valid, one result per cycle.
      ta[0] = 100; ta[1] = 200; ta[2] = 300; ta[3] = 400;
      tb[0] = 1;   tb[1] = -2;  tb[2] = 3;   tb[3] = -4;
      req_valid = 4'hF;
      for (int k = 0; k < 6; k++) begin
         #1 chk("fair ready", int'(req_ready), 1 << seq[k]);
         if (k > 0) chk("fair rsp_id", int'(rsp_id), seq[k-1]);
         tick();
      end
      #1 chk("fair last id", int'(rsp_id), 1);
      req_valid = '0;
      tick();

      // Backpressure: pointer is at 2, register empty.
      req_valid = 4'hF;
      rsp_ready = 1'b0;
      #1 chk("bp first ready", int'(req_ready), 4'b0100);
      tick();
      for (int k = 0; k < 3; k++) begin
         #1;
         chk("bp ready", int'(req_ready), 0);
         chk("bp rsp_id", int'(rsp_id), 2);
         chk("bp rsp_data", int'(rsp_data), 900);
         tick();
      end
      rsp_ready = 1'b1;
      #1 chk("bp release ready", int'(req_ready), 4'b1000);
      tick();
      #1;
      chk("bp next id", int'(rsp_id), 3);
      chk("bp next data", int'(rsp_data), -1600);

      // Reset mid-stream with a held result and a nonzero pointer.
      req_valid = 4'b0110;
      #1 chk("rst pre ready", int'(req_ready), 4'b0010);
      tick();
      rsp_ready = 1'b0;
      #1 chk("rst held id", int'(rsp_id), 1);
      tick();
      req_valid = 4'hF;
      ap_rst = 1'b1;
      #1;
      chk("rst ready low", int'(req_ready), 0);
      chk("rst still valid", int'(rsp_valid), 1);
      tick();
      ap_rst = 1'b0;
      #1;
      chk("rst dropped", int'(rsp_valid), 0);
      chk("rst lowest grant", int'(req_ready), 4'b0001);
      rsp_ready = 1'b1;
      tick();
      req_valid = '0;
      #1;
      chk("rst first id", int'(rsp_id), 0);
      chk("rst first data", int'(rsp_data), 100);
      tick();
      tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/detectfaces_mul_share_arb.md
Name: detectfaces_mul_share_arb

Overview:
Time-shares one 16-bit unsigned × 6-bit signed multiplier among NUM_REQ requesters. Typical requesters are Haar feature stages that weight rectangle sums by signed coefficients. Round-robin arbitration grants at most one operand pair per cycle. Each result is returned through a single registered response port, tagged with the requester index.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- A_WIDTH, 16, unsigned operand width.
- B_WIDTH, 6, signed operand width.
- P_WIDTH, 22, product width; must equal A_WIDTH+B_WIDTH.
- ID_WIDTH, 2, requester tag width; must equal clog2(NUM_REQ), minimum 1.

Ports:
- ap_clk  in  1  clock; all logic on the rising edge.
- ap_rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*A_WIDTH  unsigned operands; requester i occupies slice [i*A_WIDTH +: A_WIDTH].
- req_b  in  NUM_REQ*B_WIDTH  signed operands, sliced the same way.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accept.
- rsp_id  out  ID_WIDTH  index of the requester that issued the result.
- rsp_data  out  P_WIDTH  signed product.
- busy  out  1  high when rsp_valid is high or any req_valid is high (combinational).

Behaviour:
- Reset (ap_rst=1 at a clock edge):
  - rsp_valid=0, rsp_id=0, rsp_data=0.
  - Round-robin pointer=0.
  - Reset mid-transaction drops any held result without delivering it.
  - req_ready is forced to 0 while ap_rst=1.
- Issue slot: can_issue = !rsp_valid || rsp_ready.
- Grant (combinational):
  - When can_issue, pick the first asserted req_valid, searching from index ptr upward with wrap-around (ptr, ptr+1, … NUM_REQ-1, 0, …).
  - Assert req_ready only for that index; all others stay 0.
  - When !can_issue, req_ready is all zero.
- Handshake: a transfer occurs when req_valid[i] && req_ready[i]. Requesters must hold a_i/b_i stable and keep valid asserted until the transfer. The block never depends on ready to drive valid.
- Arithmetic:
  - product = signed({1'b0, a_i}) × signed(b_i), full precision, no truncation or saturation.
  - Bounds: 65535×(-32) = -2097120 and 65535×31 = 2031585; both fit in 22 bits signed.
  - The multiply is combinational on the granted pair and is captured in the output register.
- Latency: a transfer in cycle t produces rsp_valid=1 in cycle t+1, with rsp_id=i and rsp_data=product.
- Output register:
  - On a transfer: load rsp_data and rsp_id, set rsp_valid=1.
  - Else if rsp_ready: clear rsp_valid (rsp_data and rsp_id keep their values).
  - Else: hold all three.
  - Simultaneous drain and new transfer in one cycle is allowed, giving throughput of 1 result/cycle.
- Pointer update: on a transfer to index i, ptr ← (i+1) mod NUM_REQ. With no transfer, ptr holds. A continuously asserted requester waits at most NUM_REQ-1 grants.
- Backpressure: while rsp_ready=0 and rsp_valid=1, no grants occur and ptr is frozen.
- Single requester: it may be granted every cycle when rsp_ready=1.
- NUM_REQ not a power of two: wrap explicitly at NUM_REQ. Indices ≥ NUM_REQ are never granted.

Decomposition:
- Package detectfaces_mul_pkg holds:
  - Constants A_WIDTH=16, B_WIDTH=6, P_WIDTH=22.
  - Typedefs operand_a_t, operand_b_t, product_t.
  - A function returning the full-precision signed product, so the multiply definition is shared with the bench model.
- One sub-module, detectfaces_rr_arbiter:
  - Parameter NUM_REQ.
  - Inputs: req, enable, ap_clk, ap_rst.
  - Outputs: one-hot grant and grant index.
  - Owns ptr, updating it when enable and any req are asserted.
  - The top level contains the operand mux, multiplier and output register.

Test Plan:
- Reset then idle: after ap_rst high for 2 cycles → rsp_valid=0, rsp_data=0, req_ready=0000, busy=0.
- Single request: req 2 with a=1000, b=-3, rsp_ready=1 → req_ready=0100 in the same cycle; next cycle rsp_valid=1, rsp_id=2, rsp_data=-3000.
- Extremes: a=65535, b=-32 → -2097120; a=65535, b=31 → 2031585; a=0, b=-1 → 0.
- Fairness: all four valid every cycle, rsp_ready=1, from ptr=0 → grants 0,1,2,3,0,1 on consecutive cycles, one result per cycle, ids in that order.
- Backpressure: rsp_ready=0 for 3 cycles with a pending result → rsp_data and rsp_id stable, req_ready=0000, ptr frozen. On rsp_ready=1, the drain and the next grant occur in the same cycle.
- Reset mid-stream: assert ap_rst while rsp_valid=1 and rsp_ready=0 → next cycle rsp_valid=0 and ptr=0, and the first grant after reset goes to the lowest valid index.
